user_input_debounce: RTL and testbench
======================================

# user_input_debounce

Input-side counterpart to the LED output path on the CertusPro-NX Evaluation Board. The block captures the board's raw push-button and DIP-switch pins through I/O registers and synchronizes them to `clk_12mhz`. Each input is debounced with a per-bit state machine driven by a shared millisecond tick. The outputs are a clean, active-high level plus one-cycle press and release pulses per input.

## Interface
- `WIDTH`, 8: number of inputs debounced.
- `CLK_FREQUENCY`, 12.0e6 (real): clock frequency in Hz.
- `TICK_CYCLES`, `integer'(CLK_FREQUENCY*1.0e-3)` = 12000: clock cycles per sample tick.
- `DEBOUNCE_TICKS`, 10: consecutive agreeing samples required to change state. Must be ≥2; elaboration error otherwise.
- `ACTIVE_LOW`, 1: 1 means a pin at logic low is "pressed".
- `USEIOFF`, 1: 1 places the first capture stage in I/O registers (`syn_useioff = 1`); 0 places it in fabric (`syn_useioff = 0`). Both carry `syn_preserve = 1`.
- `clk_12mhz`, in, 1: the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sw_in`, in, WIDTH: raw board pins, asynchronous to the clock.
- `sw_level`, out, WIDTH: debounced state, 1 = pressed.
- `sw_press`, out, WIDTH: one-cycle pulse on each debounced press.
- `sw_release`, out, WIDTH: one-cycle pulse on each debounced release.

## Operation
- **Capture.** Stage 1 (`iob`) feeds stage 2 (`sync`). Then `act = sync ^ ACTIVE_LOW`.
  - Both stages reset to the inactive pin value (all ones when `ACTIVE_LOW=1`).
- **Prescaler.** Shared counter `0..TICK_CYCLES-1` with a width of `$clog2(TICK_CYCLES)`. It wraps to 0.
  - `tick` is high for the single cycle where count == `TICK_CYCLES-1`.
  - The counter resets to 0.
- **Per-bit FSM** with states OFF, WAIT_ON, ON, WAIT_OFF and a sample counter `cnt` of width `$clog2(DEBOUNCE_TICKS)`. The FSM evaluates only on edges where `tick`=1. Between ticks, state and `cnt` hold, so glitches shorter than a tick period are invisible.
  - OFF: if `act`=1, go to WAIT_ON with `cnt`=1.
  - WAIT_ON: if `act`=0, go to OFF with `cnt`=0. Else if `cnt`==`DEBOUNCE_TICKS-1`, go to ON, set `sw_level`=1, pulse `sw_press`. Else `cnt`++.
  - ON: if `act`=0, go to WAIT_OFF with `cnt`=1.
  - WAIT_OFF: mirror of WAIT_ON. On completion go to OFF, set `sw_level`=0, pulse `sw_release`. If `act`=1, go back to ON with `cnt`=0.
- **Outputs.** `sw_press` and `sw_release` are registered. Each is high for exactly one cycle, then cleared. They are never high together for the same bit.
- **Bit independence.** Bits are fully independent. Simultaneous events on several bits produce simultaneous pulses.
- **Reset.** On `rst_n` low, all FSMs go to OFF, `cnt`=0, and all outputs are 0 immediately (asynchronously). A pin already held pressed at reset release produces a normal `sw_press` after the debounce time.

## Timing
- Pin to `act`: 2 cycles.
- Debounce latency: the press is asserted on the edge of the `DEBOUNCE_TICKS`-th consecutive tick that samples `act`=1. `sw_level` rises on the same edge as `sw_press`.
- Default worst-case latency from a stable pin to `sw_level`: 2 + `DEBOUNCE_TICKS` × `TICK_CYCLES` cycles, about 10.0 ms.
- First tick after reset release: edge `TICK_CYCLES` (cycle index `TICK_CYCLES-1` counting from 0).
- Throughput: at most one level change per bit per `DEBOUNCE_TICKS` ticks.

## Structure
- Package `user_input_pkg` holds:
  - `typedef enum logic [1:0] {OFF, WAIT_ON, ON, WAIT_OFF} db_state_t`.
  - A width helper function.
- Sub-module `debounce_bit`: one FSM, `cnt`, and registered `level`/`press`/`release`. Inputs are `clk_12mhz`, `rst_n`, `tick`, `act`.
- Top level holds:
  - The `USEIOFF` generate branches (g0/g1) for the capture stages.
  - The sync stage.
  - The prescaler.
  - A generate loop of `WIDTH` `debounce_bit` instances.

## Test plan
All scenarios use `TICK_CYCLES`=10 and `DEBOUNCE_TICKS`=3, so ticks fall at cycle indices 9, 19, 29, …
- **Reset and idle.** Hold `rst_n`=0 with random `sw_in`, then release with `sw_in`=8'hFF held. Required: all outputs 0 throughout, and no pulses for 1000 cycles.
- **Clean press.** Drive `sw_in[0]`=0 at cycle 2. Required:
  - `act` is seen at ticks 9 and 19.
  - At the edge of cycle 29, `sw_level[0]`=1 and `sw_press[0]`=1 for exactly one cycle.
  - Other bits stay 0.
- **Bounce.** Toggle `sw_in[3]` every 3 cycles for 60 cycles, then hold it at 0. Required: exactly one `sw_press[3]` pulse, on the third consecutive active tick after settling. `sw_level[3]` never toggles back.
- **Interrupted press.** Bit 1 is active at ticks 9 and 19 and inactive at tick 29. Required: no pulse, and the FSM returns to OFF. Re-pressing before tick 39 yields a press at tick 59.
- **Release.** From ON, drive the pin to 1. Required: `sw_release` pulses once on the third inactive tick and `sw_level` falls on the same edge. Simultaneous release of bits 0 and 7 gives simultaneous pulses.
- **Mid-operation reset.** Assert `rst_n`=0 in WAIT_ON and again in ON while the pin is held at 0. Required:
  - Outputs go to 0 asynchronously, within the same cycle.
  - After release, `sw_press` fires at the third tick (cycle 29 after release).

Source files
------------

// File: rtl/user_input_pkg.sv
// Shared types and helpers for the push-button / DIP-switch
// debounce path.
package user_input_pkg;

  typedef enum logic [1:0] {
    OFF,
    WAIT_ON,
    ON,
    WAIT_OFF
  } db_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/user_input_debounce_bit.sv
// Single-input debounce FSM, advanced only on the shared sample tick,
// with registered level and one-cycle press/release pulses.
module debounce_bit
  import user_input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic clk_12mhz,
  input  logic rst_n,
  input  logic tick,
  input  logic act,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_w(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        unique case (state)
          OFF: begin
            if (act) begin
              state <= WAIT_ON;
              cnt   <= ONE;
            end
          end
          WAIT_ON: begin
            if (!act) begin
              state <= OFF;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= ON;
              cnt   <= '0;
              level <= 1'b1;
              press <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          ON: begin
            if (!act) begin
              state <= WAIT_OFF;
              cnt   <= ONE;
            end
          end
          WAIT_OFF: begin
            if (act) begin
              state <= ON;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= OFF;
              cnt   <= '0;
              level <= 1'b0;
              rel   <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state <= OFF;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/user_input_debounce.sv
// Board input capture, synchronizer, shared millisecond prescaler and
// a bank of per-input debounce FSMs.
module user_input_debounce
  import user_input_pkg::*;
#(
  parameter int  WIDTH          = 8,
  parameter real CLK_FREQUENCY  = 12.0e6,
  parameter int  TICK_CYCLES    = integer'(CLK_FREQUENCY * 1.0e-3),
  parameter int  DEBOUNCE_TICKS = 10,
  parameter bit  ACTIVE_LOW     = 1'b1,
  parameter bit  USEIOFF        = 1'b1
) (
  input  logic             clk_12mhz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_press,
  output logic [WIDTH-1:0] sw_release
);

  localparam logic [WIDTH-1:0] IDLE = {WIDTH{ACTIVE_LOW}};
  localparam int TW = cnt_w(TICK_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TONE = TW'(1);

  if (DEBOUNCE_TICKS < 2) begin : g_chk
    $error("DEBOUNCE_TICKS must be at least 2");
  end

  logic [WIDTH-1:0] iob_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] act;

  // Resetting to the idle pin value keeps reset release press-free.
  if (USEIOFF) begin : g1
    (* syn_useioff = 1, syn_preserve = 1 *)
    logic [WIDTH-1:0] iob;
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
      if (!rst_n) iob <= IDLE;
      else        iob <= sw_in;
    end
    assign iob_q = iob;
  end else begin : g0
    (* syn_useioff = 0, syn_preserve = 1 *)
    logic [WIDTH-1:0] iob;
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
      if (!rst_n) iob <= IDLE;
      else        iob <= sw_in;
    end
    assign iob_q = iob;
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) sync <= IDLE;
    else        sync <= iob_q;
  end

  assign act = sync ^ IDLE;

  logic [TW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == TLAST);

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n)    pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + TONE;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_db (
      .clk_12mhz(clk_12mhz),
      .rst_n    (rst_n),
      .tick     (tick),
      .act      (act[i]),
      .level    (sw_level[i]),
      .press    (sw_press[i]),
      .rel      (sw_release[i])
    );
  end

endmodule

// File: tb/tb_user_input_debounce.sv
// Directed bench for user_input_debounce with a 10-cycle tick and
// 3-sample debounce window.
module tb_user_input_debounce;
  import user_input_pkg::*;

  logic       clk_12mhz = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] sw_in = 8'hFF;
  logic [7:0] sw_level;
  logic [7:0] sw_press;
  logic [7:0] sw_release;

  int n_chk = 0;
  int n_pass = 0;
  int ec = 0;
  int pc [8];
  int rc [8];

  typedef struct {
    int         edges;
    logic [7:0] sw;
    logic [7:0] lvl;
    logic [7:0] prs;
    logic [7:0] rls;
  } vec_t;

  vec_t vt [10];

  always #5 clk_12mhz = ~clk_12mhz;

  user_input_debounce #(
    .WIDTH         (8),
    .TICK_CYCLES   (10),
    .DEBOUNCE_TICKS(3),
    .ACTIVE_LOW    (1'b1),
    .USEIOFF       (1'b1)
  ) dut (
    .clk_12mhz (clk_12mhz),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .sw_level  (sw_level),
    .sw_press  (sw_press),
    .sw_release(sw_release)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  task automatic clr();
    for (int b = 0; b < 8; b++) begin
      pc[b] = 0;
      rc[b] = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_12mhz);
      ec++;
      #1;
      chk("overlap", 32'(sw_press & sw_release), 32'd0);
      for (int b = 0; b < 8; b++) begin
        pc[b] += int'(sw_press[b]);
        rc[b] += int'(sw_release[b]);
      end
    end
  endtask

  task automatic outs(input string nm,
                      input logic [7:0] l,
                      input logic [7:0] p,
                      input logic [7:0] r);
    chk({nm, "_lvl"}, 32'(sw_level), 32'(l));
    chk({nm, "_prs"}, 32'(sw_press), 32'(p));
    chk({nm, "_rls"}, 32'(sw_release), 32'(r));
  endtask

  task automatic hold_reset(input string nm, input int n);
    rst_n = 1'b0;
    #1;
    outs({nm, "_async"}, 8'h00, 8'h00, 8'h00);
    step(n);
    rst_n = 1'b1;
    ec = 0;
    clr();
  endtask

  initial begin
    vt[0] = '{2,  8'hFF, 8'h00, 8'h00, 8'h00};
    vt[1] = '{27, 8'hFE, 8'h00, 8'h00, 8'h00};
    vt[2] = '{1,  8'hFE, 8'h01, 8'h01, 8'h00};
    vt[3] = '{1,  8'hFE, 8'h01, 8'h00, 8'h00};
    vt[4] = '{28, 8'h7E, 8'h01, 8'h00, 8'h00};
    vt[5] = '{1,  8'h7E, 8'h81, 8'h80, 8'h00};
    vt[6] = '{1,  8'h7E, 8'h81, 8'h00, 8'h00};
    vt[7] = '{28, 8'hFF, 8'h81, 8'h00, 8'h00};
    vt[8] = '{1,  8'hFF, 8'h00, 8'h00, 8'h81};
    vt[9] = '{1,  8'hFF, 8'h00, 8'h00, 8'h00};
    clr();

    // reset with noisy pins, then a long idle stretch
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      sw_in = 8'($urandom);
      step(1);
      outs("rst_hold", 8'h00, 8'h00, 8'h00);
    end
    sw_in = 8'hFF;
    rst_n = 1'b1;
    ec = 0;
    clr();
    step(1000);
    chk("idle_lvl", 32'(sw_level), 32'd0);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("idle_prs%0d", b), 32'(pc[b]), 32'd0);
      chk($sformatf("idle_rls%0d", b), 32'(rc[b]), 32'd0);
    end

    // clean press, second press, simultaneous release
    sw_in = 8'hFF;
    hold_reset("tbl_rst", 3);
    for (int i = 0; i < 10; i++) begin
      sw_in = vt[i].sw;
      step(vt[i].edges);
      outs($sformatf("vec%0d", i), vt[i].lvl, vt[i].prs, vt[i].rls);
    end
    chk("tbl_prs0", 32'(pc[0]), 32'd1);
    chk("tbl_prs7", 32'(pc[7]), 32'd1);
    chk("tbl_rls0", 32'(rc[0]), 32'd1);
    chk("tbl_rls7", 32'(rc[7]), 32'd1);
    chk("tbl_prs1", 32'(pc[1]), 32'd0);

    // bounce on bit 3
    sw_in = 8'hFF;
    hold_reset("bnc_rst", 3);
    for (int k = 0; k < 60; k++) begin
      sw_in[3] = ((k / 3) % 2) != 0;
      step(1);
    end
    sw_in[3] = 1'b0;
    step(29);
    chk("bnc_lvl89", 32'(sw_level[3]), 32'd0);
    chk("bnc_cnt89", 32'(pc[3]), 32'd0);
    step(1);
    outs("bnc90", 8'h08, 8'h08, 8'h00);
    step(40);
    chk("bnc_lvl130", 32'(sw_level), 32'h08);
    chk("bnc_prs", 32'(pc[3]), 32'd1);
    chk("bnc_rls", 32'(rc[3]), 32'd0);

    // interrupted press on bit 1, then a re-press
    sw_in = 8'hFF;
    hold_reset("int_rst", 3);
    step(2);
    sw_in[1] = 1'b0;
    step(20);
    sw_in[1] = 1'b1;
    step(9);
    chk("int_state", 32'(dut.g_bit[1].u_db.state), 32'(OFF));
    chk("int_noprs", 32'(pc[1]), 32'd0);
    step(1);
    sw_in[1] = 1'b0;
    step(27);
    outs("int59", 8'h00, 8'h00, 8'h00);
    step(1);
    outs("int60", 8'h02, 8'h02, 8'h00);
    chk("int_prs", 32'(pc[1]), 32'd1);

    // reset mid-debounce and while ON, pin held pressed
    sw_in = 8'hFB;
    hold_reset("mid_rst0", 3);
    step(12);
    chk("mid_wait", 32'(dut.g_bit[2].u_db.state), 32'(WAIT_ON));
    hold_reset("mid_rst1", 2);
    chk("mid_off", 32'(dut.g_bit[2].u_db.state), 32'(OFF));
    step(29);
    outs("mid29", 8'h00, 8'h00, 8'h00);
    step(1);
    outs("mid30", 8'h04, 8'h04, 8'h00);
    step(5);
    chk("mid_on", 32'(sw_level), 32'h04);
    hold_reset("mid_rst2", 2);
    step(29);
    outs("mid2_29", 8'h00, 8'h00, 8'h00);
    step(1);
    outs("mid2_30", 8'h04, 8'h04, 8'h00);
    step(1);
    outs("mid2_31", 8'h04, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
